// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the RV32I front end: fetch sequencer state
//   encoding, instruction length/alignment, and the base opcode map that
//   the decoder also uses.
package riscv_pkg;

   localparam int unsigned ILEN        = 32;
   localparam int unsigned INSTR_ALIGN = 4;

   localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
   localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
   localparam logic [6:0] OPC_STORE    = 7'b010_0011;
   localparam logic [6:0] OPC_OP       = 7'b011_0011;
   localparam logic [6:0] OPC_LUI      = 7'b011_0111;
   localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
   localparam logic [6:0] OPC_JALR     = 7'b110_0111;
   localparam logic [6:0] OPC_JAL      = 7'b110_1111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/riscv_fetch_ir.sv
// riscv_fetch_ir
//   Instruction register between fetch and decode. Holds one instruction
//   word with its PC and a pre-computed illegal flag.
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : capture pc_i/ins_i and raise valid_o
//   clear_i     : drop valid_o (pc/ins keep their last values)
//   pc_i, ins_i : PC and word to capture
//   valid_o     : instruction held
//   pc_o, ins_o : held PC and instruction word
//   illegal_o   : held word is not a 32-bit encoding (ins[1:0] != 2'b11)
module riscv_fetch_ir
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_i,
   input  logic            clear_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [ILEN-1:0] ins_i,
   output logic            valid_o,
   output logic [XLEN-1:0] pc_o,
   output logic [ILEN-1:0] ins_o,
   output logic            illegal_o
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_o   <= 1'b0;
         pc_o      <= '0;
         ins_o     <= '0;
         illegal_o <= 1'b0;
      end else if (load_i) begin
         valid_o   <= 1'b1;
         pc_o      <= pc_i;
         ins_o     <= ins_i;
         illegal_o <= (ins_i[1:0] != 2'b11);
      end else if (clear_i) begin
         valid_o   <= 1'b0;
      end
   end

endmodule

// File: rtl/riscv_fetch_ctrl.sv
// riscv_fetch_ctrl
//   Instruction fetch sequencer: one outstanding imem request at a time,
//   response captured into riscv_fetch_ir and offered to decode with a
//   valid/ready handshake. Execute redirects override everything; a
//   response already in flight when a redirect hits is discarded.
// Configuration
//   RV_FETCH_PERF_EN : when defined, perf_fetched/perf_stall are live
//                      32-bit wrapping counters; otherwise both are 0.
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   imem_req/addr/gnt          : request channel to instruction memory
//   imem_rvalid/rdata          : response channel from instruction memory
//   id_valid/ready             : handshake to decode
//   id_pc, id_ins, id_illegal  : presented instruction
//   redirect_valid/pc          : branch/jump redirect from execute
//   perf_fetched, perf_stall   : performance counters
module riscv_fetch_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [ILEN-1:0] id_ins,
   output logic            id_illegal,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_stall
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            discard_q, discard_d;
   logic            started_q;
   logic            ir_load, ir_clear;

   // Request is held low for the first cycle after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH_REQ;
         pc_q      <= RESET_PC;
         discard_q <= 1'b0;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         discard_q <= discard_d;
         started_q <= 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      discard_d = discard_q;
      ir_load   = 1'b0;
      ir_clear  = 1'b0;
      imem_req  = 1'b0;

      unique case (state_q)
         FETCH_REQ: begin
            imem_req = started_q;
            if (started_q && imem_gnt) begin
               state_d   = FETCH_WAIT;
               // Redirect in the grant cycle: the accepted fetch is stale.
               discard_d = redirect_valid;
            end
         end
         FETCH_WAIT: begin
            if (imem_rvalid) begin
               if (discard_q || redirect_valid) begin
                  discard_d = 1'b0;
                  state_d   = FETCH_REQ;
               end else begin
                  ir_load = 1'b1;
                  state_d = FETCH_HOLD;
               end
            end else if (redirect_valid) begin
               discard_d = 1'b1;
            end
         end
         FETCH_HOLD: begin
            // Redirect wins over a simultaneous decode accept.
            if (redirect_valid) begin
               ir_clear = 1'b1;
               state_d  = FETCH_REQ;
            end else if (id_ready) begin
               ir_clear = 1'b1;
               pc_d     = pc_q + XLEN'(INSTR_ALIGN);
               state_d  = FETCH_REQ;
            end
         end
         default: state_d = FETCH_REQ;
      endcase

      if (redirect_valid) begin
         pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      end
   end

   assign imem_addr = pc_q;

   riscv_fetch_ir #(
      .XLEN (XLEN)
   ) u_ir (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (ir_load),
      .clear_i   (ir_clear),
      .pc_i      (pc_q),
      .ins_i     (imem_rdata),
      .valid_o   (id_valid),
      .pc_o      (id_pc),
      .ins_o     (id_ins),
      .illegal_o (id_illegal)
   );

`ifdef RV_FETCH_PERF_EN
   logic [31:0] fetched_q, stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetched_q <= '0;
         stall_q   <= '0;
      end else begin
         if (id_valid && id_ready && !redirect_valid) begin
            fetched_q <= fetched_q + 32'd1;
         end
         if (!id_valid) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_stall   = stall_q;
`else
   assign perf_fetched = '0;
   assign perf_stall   = '0;
`endif

`ifndef SYNTHESIS
   // A response with no request outstanding is a memory protocol error.
   a_rvalid_in_wait : assert property (@(posedge clk) disable iff (!rst_n)
      imem_rvalid |-> (state_q == FETCH_WAIT))
      else $error("imem_rvalid outside WAIT");
`endif

endmodule
